// File: rtl/present_masked_pkg.sv
// Shared FSM type, constants and pLayer index map for the masked PRESENT round controller.
package present_masked_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADD,
    ST_SBOX,
    ST_PERM,
    ST_FINAL,
    ST_DONE
  } state_e;

  localparam int NIBBLES = 16;

  // Destination of source bit i in the PRESENT bit permutation.
  function automatic int perm_idx(input int i);
    return (i == 63) ? 63 : (16 * i) % 63;
  endfunction
endpackage

// File: rtl/present_player.sv
// Combinational PRESENT bit permutation for one 64-bit share (wiring only).
module present_player
  import present_masked_pkg::*;
(
  input  logic [63:0] d_i,
  output logic [63:0] q_o
);
  for (genvar gi = 0; gi < 64; gi++) begin : g_bit
    assign q_o[perm_idx(gi)] = d_i[gi];
  end
endmodule

// File: rtl/present_masked_round_ctrl.sv
// Nibble-serial two-share PRESENT round engine; the external masked S-box must return
// sb_y SBOX_LAT-1 cycles after sb_x changes, so the sb_x flop counts as its first stage.
module present_masked_round_ctrl
  import present_masked_pkg::*;
#(
  parameter int SBOX_LAT = 3,
  parameter int ROUNDS   = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] pt_s0,
  input  logic [63:0] pt_s1,
  input  logic [63:0] rk_s0,
  input  logic [63:0] rk_s1,
  output logic [4:0]  round_idx,
  output logic [3:0]  sb_x_s0,
  output logic [3:0]  sb_x_s1,
  input  logic [3:0]  sb_y_s0,
  input  logic [3:0]  sb_y_s1,
  output logic        busy,
  output logic        done,
  output logic [63:0] ct_s0,
  output logic [63:0] ct_s1
);
  localparam int SBOX_CYC = NIBBLES + SBOX_LAT;
  localparam int CW       = $clog2(SBOX_CYC);

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]  round_q, round_d;
  logic [63:0] st0_q, st0_d, st1_q, st1_d;
  logic [63:0] buf0_q, buf0_d, buf1_q, buf1_d;
  logic [63:0] ct0_q, ct0_d, ct1_q, ct1_d;
  logic [3:0]  sbx0_q, sbx0_d, sbx1_q, sbx1_d;
  logic        busy_q, busy_d, done_q, done_d;
  logic [63:0] perm0, perm1;
  logic        issue, capture;
  logic [3:0]  iss, cap;

  present_player u_player_s0 (.d_i(buf0_q), .q_o(perm0));
  present_player u_player_s1 (.d_i(buf1_q), .q_o(perm1));

  // One counter drives both the issue index and the delayed capture index.
  assign issue   = (state_q == ST_SBOX) && (cnt_q < CW'(NIBBLES));
  assign capture = (state_q == ST_SBOX) && (cnt_q >= CW'(SBOX_LAT));
  assign iss     = cnt_q[3:0];
  assign cap     = 4'(cnt_q - CW'(SBOX_LAT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      round_q <= '0;
      st0_q   <= '0;
      st1_q   <= '0;
      buf0_q  <= '0;
      buf1_q  <= '0;
      ct0_q   <= '0;
      ct1_q   <= '0;
      sbx0_q  <= '0;
      sbx1_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      round_q <= round_d;
      st0_q   <= st0_d;
      st1_q   <= st1_d;
      buf0_q  <= buf0_d;
      buf1_q  <= buf1_d;
      ct0_q   <= ct0_d;
      ct1_q   <= ct1_d;
      sbx0_q  <= sbx0_d;
      sbx1_q  <= sbx1_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    round_d = round_q;
    st0_d   = st0_q;
    st1_d   = st1_q;
    buf0_d  = buf0_q;
    buf1_d  = buf1_q;
    ct0_d   = ct0_q;
    ct1_d   = ct1_q;
    sbx0_d  = '0;
    sbx1_d  = '0;
    busy_d  = busy_q;
    done_d  = 1'b0;

    if (issue) begin
      sbx0_d = st0_q[{iss, 2'b00} +: 4];
      sbx1_d = st1_q[{iss, 2'b00} +: 4];
    end
    // Captures land in the buffer so nibbles still waiting to issue stay intact.
    if (capture) begin
      buf0_d[{cap, 2'b00} +: 4] = sb_y_s0;
      buf1_d[{cap, 2'b00} +: 4] = sb_y_s1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          st0_d   = pt_s0;
          st1_d   = pt_s1;
          round_d = '0;
          busy_d  = 1'b1;
          state_d = ST_ADD;
        end
      end
      ST_ADD: begin
        st0_d   = st0_q ^ rk_s0;
        st1_d   = st1_q ^ rk_s1;
        cnt_d   = '0;
        state_d = ST_SBOX;
      end
      ST_SBOX: begin
        if (cnt_q == CW'(SBOX_CYC - 1)) begin
          cnt_d   = '0;
          state_d = ST_PERM;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_PERM: begin
        st0_d   = perm0;
        st1_d   = perm1;
        round_d = round_q + 5'd1;
        state_d = (round_q == 5'(ROUNDS - 1)) ? ST_FINAL : ST_ADD;
      end
      ST_FINAL: begin
        st0_d   = st0_q ^ rk_s0;
        st1_d   = st1_q ^ rk_s1;
        ct0_d   = st0_q ^ rk_s0;
        ct1_d   = st1_q ^ rk_s1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign round_idx = round_q;
  assign sb_x_s0   = sbx0_q;
  assign sb_x_s1   = sbx1_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign ct_s0     = ct0_q;
  assign ct_s1     = ct1_q;
endmodule

// File: tb/tb_present_masked_round_ctrl.sv
// Self-checking bench: two DUT builds (S-box latency 3 and 5) against a plain PRESENT-80 model.
`timescale 1ns/1ps
module tb_present_masked_round_ctrl;
  localparam int LAT_A     = 3;
  localparam int LAT_B     = 5;
  localparam int ROUNDS    = 31;
  localparam int LATENCY_A = ROUNDS * (18 + LAT_A) + 2;
  localparam int LATENCY_B = ROUNDS * (18 + LAT_B) + 2;
  localparam int TIMEOUT   = 1000;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [63:0] pt_s0, pt_s1;
  logic [63:0] rk0_a, rk1_a, rk0_b, rk1_b;
  logic [4:0]  ridx_a, ridx_b;
  logic [3:0]  sbx0_a, sbx1_a, sby0_a, sby1_a;
  logic [3:0]  sbx0_b, sbx1_b, sby0_b, sby1_b;
  logic        busy_a, done_a, busy_b, done_b;
  logic [63:0] ct0_a, ct1_a, ct0_b, ct1_b;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] keys  [0:31];
  logic [63:0] kmask [0:31];
  bit          stuck_s1 = 1'b0;

  always #5 clk = ~clk;

  present_masked_round_ctrl #(.SBOX_LAT(LAT_A), .ROUNDS(ROUNDS)) dut_a (
    .clk(clk), .rst(rst), .start(start), .pt_s0(pt_s0), .pt_s1(pt_s1),
    .rk_s0(rk0_a), .rk_s1(rk1_a), .round_idx(ridx_a),
    .sb_x_s0(sbx0_a), .sb_x_s1(sbx1_a), .sb_y_s0(sby0_a), .sb_y_s1(sby1_a),
    .busy(busy_a), .done(done_a), .ct_s0(ct0_a), .ct_s1(ct1_a));

  present_masked_round_ctrl #(.SBOX_LAT(LAT_B), .ROUNDS(ROUNDS)) dut_b (
    .clk(clk), .rst(rst), .start(start), .pt_s0(pt_s0), .pt_s1(pt_s1),
    .rk_s0(rk0_b), .rk_s1(rk1_b), .round_idx(ridx_b),
    .sb_x_s0(sbx0_b), .sb_x_s1(sbx1_b), .sb_y_s0(sby0_b), .sb_y_s1(sby1_b),
    .busy(busy_b), .done(done_b), .ct_s0(ct0_b), .ct_s1(ct1_b));

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [63:0] tbl;
    tbl = 64'h21748FE3DA09B65C;
    return tbl[x*4 +: 4];
  endfunction

  // Round-key shares follow whatever round each DUT is on.
  assign rk1_a = kmask[ridx_a];
  assign rk0_a = keys[ridx_a] ^ kmask[ridx_a];
  assign rk1_b = kmask[ridx_b];
  assign rk0_b = keys[ridx_b] ^ kmask[ridx_b];

  // Behavioural masked S-boxes: LAT-1 stages after the DUT's sb_x flop, fresh output mask each cycle.
  logic [3:0] pa0 [0:LAT_A-2];
  logic [3:0] pa1 [0:LAT_A-2];
  logic [3:0] pb0 [0:LAT_B-2];
  logic [3:0] pb1 [0:LAT_B-2];
  logic [3:0] ra, rb;
  always @(posedge clk) begin
    pa0[0] <= sbx0_a;
    pa1[0] <= sbx1_a;
    for (int i = 1; i < LAT_A - 1; i++) begin
      pa0[i] <= pa0[i-1];
      pa1[i] <= pa1[i-1];
    end
    pb0[0] <= sbx0_b;
    pb1[0] <= sbx1_b;
    for (int j = 1; j < LAT_B - 1; j++) begin
      pb0[j] <= pb0[j-1];
      pb1[j] <= pb1[j-1];
    end
    ra <= 4'($urandom);
    rb <= 4'($urandom);
  end
  assign sby1_a = stuck_s1 ? 4'h0 : ra;
  assign sby0_a = sbox(pa0[LAT_A-2] ^ pa1[LAT_A-2]) ^ ra;
  assign sby1_b = rb;
  assign sby0_b = sbox(pb0[LAT_B-2] ^ pb1[LAT_B-2]) ^ rb;

  // sb_x may only move on a clock edge (or on reset).
  realtime last_edge = 0.0;
  int      glitches  = 0;
  always @(posedge clk) last_edge = $realtime;
  always @(sbx0_a or sbx1_a or sbx0_b or sbx1_b)
    if (!rst && $realtime != last_edge) glitches++;

  function automatic logic [63:0] present_ref(input logic [63:0] pt, input logic [79:0] key);
    logic [79:0] k;
    logic [63:0] s, t;
    k = key;
    s = pt;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ k[79:16];
      for (int n = 0; n < 16; n++) s[n*4 +: 4] = sbox(s[n*4 +: 4]);
      t = '0;
      for (int i = 0; i < 64; i++) t[(i == 63) ? 63 : (i * 16) % 63] = s[i];
      s = t;
      k = {k[18:0], k[79:19]};
      k[79:76] = sbox(k[79:76]);
      k[19:15] = k[19:15] ^ 5'(r);
    end
    return s ^ k[79:16];
  endfunction

  task automatic make_keys(input logic [79:0] key);
    logic [79:0] k;
    k = key;
    for (int i = 0; i < 32; i++) begin
      if (i > 0) begin
        k = {k[18:0], k[79:19]};
        k[79:76] = sbox(k[79:76]);
        k[19:15] = k[19:15] ^ 5'(i);
      end
      keys[i]  = k[79:16];
      kmask[i] = {$urandom, $urandom};
    end
  endtask

  function automatic logic [79:0] rand80();
    return {$urandom, $urandom, 16'($urandom)};
  endfunction

  // Starts one encryption (caller sits #1 after an edge, both DUTs idle) and waits for both dones.
  task automatic run_enc(input logic [63:0] pt, input logic [79:0] key, input logic [63:0] mask,
                         input int inj1, input int inj2,
                         output logic [63:0] c0, output logic [63:0] c1,
                         output int lat_a, output int lat_b);
    make_keys(key);
    pt_s1 = mask;
    pt_s0 = pt ^ mask;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    c0 = '0;
    c1 = '0;
    lat_a = -1;
    lat_b = -1;
    for (int c = 1; c <= TIMEOUT && (lat_a < 0 || lat_b < 0); c++) begin
      if (c - 1 == inj1 || c - 1 == inj2) begin
        start = 1'b1;
        pt_s0 = ~pt_s0;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done_a && lat_a < 0) begin
        lat_a = c;
        c0 = ct0_a;
        c1 = ct1_a;
      end
      if (done_b && lat_b < 0) lat_b = c;
    end
    start = 1'b0;
    $display("enc pt=%h key=%h ct=%h lat_a=%0d lat_b=%0d", pt, key, c0 ^ c1, lat_a, lat_b);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    pt_s0 = '0;
    pt_s1 = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_a); end
    n_checks++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done_a); end
    n_checks++; if (ridx_a !== 5'd0) begin n_fail++; $display("FAIL reset_round_idx: got %0d want 0", ridx_a); end
    n_checks++; if (ct0_a !== 64'd0 || ct1_a !== 64'd0) begin n_fail++; $display("FAIL reset_ct: got %h/%h want 0", ct0_a, ct1_a); end
    n_checks++; if (sbx0_a !== 4'd0 || sbx1_a !== 4'd0) begin n_fail++; $display("FAIL reset_sbx: got %h/%h want 0", sbx0_a, sbx1_a); end
    n_checks++; if (busy_b !== 1'b0 || done_b !== 1'b0 || ridx_b !== 5'd0) begin n_fail++; $display("FAIL reset_b_ctrl: got busy %b done %b idx %0d want 0", busy_b, done_b, ridx_b); end
    rst = 1'b0;
    @(posedge clk); #1;
    $display("reset check done");
  endtask

  task automatic test_kat();
    logic [63:0] c0, c1, pt, exp_ct;
    logic [79:0] key;
    int la, lb;
    for (int t = 0; t < 2; t++) begin
      pt     = (t == 0) ? 64'h0 : 64'hFFFF_FFFF_FFFF_FFFF;
      key    = (t == 0) ? 80'h0 : 80'hFFFF_FFFF_FFFF_FFFF_FFFF;
      exp_ct = (t == 0) ? 64'h5579C1387B228445 : 64'h3333DCD3213210D2;
      run_enc(pt, key, {$urandom, $urandom}, -1, -1, c0, c1, la, lb);
      n_checks++; if ((c0 ^ c1) !== exp_ct) begin n_fail++; $display("FAIL kat%0d_ct: got %h want %h", t, c0 ^ c1, exp_ct); end
      n_checks++; if (la !== LATENCY_A) begin n_fail++; $display("FAIL kat%0d_latency: got %0d want %0d", t, la, LATENCY_A); end
      n_checks++; if ((ct0_b ^ ct1_b) !== exp_ct) begin n_fail++; $display("FAIL kat%0d_ct_lat5: got %h want %h", t, ct0_b ^ ct1_b, exp_ct); end
      n_checks++; if (lb !== LATENCY_B) begin n_fail++; $display("FAIL kat%0d_latency_lat5: got %0d want %0d", t, lb, LATENCY_B); end
    end
  endtask

  task automatic test_mask_independence();
    logic [63:0] c0, c1, pt, exp_ct, prev_c1;
    logic [79:0] key;
    int la, lb;
    pt = {$urandom, $urandom};
    key = rand80();
    exp_ct = present_ref(pt, key);
    prev_c1 = '0;
    for (int r = 0; r < 40; r++) begin
      run_enc(pt, key, {$urandom, $urandom}, -1, -1, c0, c1, la, lb);
      n_checks++; if ((c0 ^ c1) !== exp_ct) begin n_fail++; $display("FAIL mask_ct run %0d: got %h want %h", r, c0 ^ c1, exp_ct); end
      if (r > 0) begin
        n_checks++; if (c1 === prev_c1) begin n_fail++; $display("FAIL mask_share_varies run %0d: ct_s1 %h repeated, want a fresh value", r, c1); end
      end
      prev_c1 = c1;
    end
  endtask

  task automatic test_start_while_busy();
    logic [63:0] c0, c1, pt, exp_ct;
    logic [79:0] key;
    int la, lb;
    pt = {$urandom, $urandom};
    key = rand80();
    exp_ct = present_ref(pt, key);
    run_enc(pt, key, {$urandom, $urandom}, 5, 300, c0, c1, la, lb);
    n_checks++; if ((c0 ^ c1) !== exp_ct) begin n_fail++; $display("FAIL busy_start_ct: got %h want %h", c0 ^ c1, exp_ct); end
    n_checks++; if (la !== LATENCY_A) begin n_fail++; $display("FAIL busy_start_latency: got %0d want %0d", la, LATENCY_A); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] p1, p2, e1, e2;
    logic [79:0] key;
    int t2;
    p1 = {$urandom, $urandom};
    p2 = {$urandom, $urandom};
    key = rand80();
    e1 = present_ref(p1, key);
    e2 = present_ref(p2, key);
    make_keys(key);
    pt_s1 = {$urandom, $urandom};
    pt_s0 = p1 ^ pt_s1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (LATENCY_A - 1) @(posedge clk);
    #1;
    n_checks++; if (done_a !== 1'b0 || busy_a !== 1'b1) begin n_fail++; $display("FAIL b2b_done_state: got done %b busy %b want 0/1", done_a, busy_a); end
    pt_s1 = {$urandom, $urandom};
    pt_s0 = p2 ^ pt_s1;
    start = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (done_a !== 1'b1 || busy_a !== 1'b0) begin n_fail++; $display("FAIL b2b_done_pulse: got done %b busy %b want 1/0", done_a, busy_a); end
    n_checks++; if ((ct0_a ^ ct1_a) !== e1) begin n_fail++; $display("FAIL b2b_first_ct: got %h want %h", ct0_a ^ ct1_a, e1); end
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: got busy %b want 1", busy_a); end
    t2 = -1;
    for (int c = 1; c <= TIMEOUT && t2 < 0; c++) begin
      @(posedge clk); #1;
      if (done_a) t2 = c;
    end
    $display("enc b2b pt=%h ct=%h lat=%0d", p2, ct0_a ^ ct1_a, t2);
    n_checks++; if (t2 !== LATENCY_A) begin n_fail++; $display("FAIL b2b_latency: got %0d want %0d", t2, LATENCY_A); end
    n_checks++; if ((ct0_a ^ ct1_a) !== e2) begin n_fail++; $display("FAIL b2b_second_ct: got %h want %h", ct0_a ^ ct1_a, e2); end
    repeat (LATENCY_B) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_midop();
    logic [63:0] c0, c1, p, exp_ct;
    logic [79:0] key;
    int la, lb;
    p = {$urandom, $urandom};
    key = rand80();
    make_keys(key);
    pt_s1 = {$urandom, $urandom};
    pt_s0 = p ^ pt_s1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL midop_busy_before: got %b want 1", busy_a); end
    rst = 1'b1;
    #1;
    n_checks++; if (busy_a !== 1'b0 || done_a !== 1'b0 || ridx_a !== 5'd0) begin n_fail++; $display("FAIL midop_reset_ctrl: got busy %b done %b idx %0d want 0", busy_a, done_a, ridx_a); end
    n_checks++; if (ct0_a !== 64'd0 || ct1_a !== 64'd0 || sbx0_a !== 4'd0 || sbx1_a !== 4'd0) begin n_fail++; $display("FAIL midop_reset_data: got ct %h/%h sbx %h/%h want 0", ct0_a, ct1_a, sbx0_a, sbx1_a); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    p = {$urandom, $urandom};
    key = rand80();
    exp_ct = present_ref(p, key);
    run_enc(p, key, {$urandom, $urandom}, -1, -1, c0, c1, la, lb);
    n_checks++; if ((c0 ^ c1) !== exp_ct) begin n_fail++; $display("FAIL midop_restart_ct: got %h want %h", c0 ^ c1, exp_ct); end
    n_checks++; if (la !== LATENCY_A) begin n_fail++; $display("FAIL midop_restart_latency: got %0d want %0d", la, LATENCY_A); end
  endtask

  task automatic test_stuck_s1();
    logic [63:0] c0, c1, p, exp_ct;
    logic [79:0] key;
    int la, lb;
    p = {$urandom, $urandom};
    key = rand80();
    exp_ct = present_ref(p, key);
    stuck_s1 = 1'b1;
    run_enc(p, key, {$urandom, $urandom}, -1, -1, c0, c1, la, lb);
    stuck_s1 = 1'b0;
    n_checks++; if ((c0 ^ c1) === exp_ct) begin n_fail++; $display("FAIL stuck_corrupts: got %h, want anything but %h", c0 ^ c1, exp_ct); end
    n_checks++; if (c0 === p || c0 === exp_ct) begin n_fail++; $display("FAIL stuck_s0_hides: got ct_s0 %h, want neither pt %h nor ct %h", c0, p, exp_ct); end
  endtask

  task automatic test_share_isolation();
    n_checks++; if (glitches !== 0) begin n_fail++; $display("FAIL sbx_edge_only: got %0d off-edge changes want 0", glitches); end
  endtask

  initial begin
    test_reset();
    test_kat();
    test_mask_independence();
    test_start_while_busy();
    test_back_to_back();
    test_reset_midop();
    test_stuck_s1();
    test_share_isolation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
